// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler time-sharing one serial sequence detector among N requesters.
// Build macro SEQ_SCHED_TIMEOUT_EN adds the resp_drop output and a bounded wait in DONE.
module seq_det_scheduler #(
  parameter int N       = 2,
  parameter int W       = 8,
  parameter int LAT     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         req_data,
  output logic [N-1:0]           gnt,
  output logic                   busy,
  output logic                   det_rst,
  output logic                   det_x,
  input  logic [1:0]             det_y,
  output logic                   resp_valid,
`ifdef SEQ_SCHED_TIMEOUT_EN
  output logic                   resp_drop,
`endif
  input  logic                   resp_ready,
  output logic [$clog2(N)-1:0]   resp_id,
  output logic [$clog2(W+1)-1:0] resp_count,
  output logic [1:0]             resp_last_y
);

  localparam int PW   = $clog2(N);
  localparam int CNTW = $clog2(W+1);
  localparam int CW   = $clog2(W+LAT+1);
  localparam logic [CW-1:0] SHIFT_LAST   = CW'(W-1);
  localparam logic [CW-1:0] DRAIN_LAST   = CW'(W+LAT-1);
  localparam logic [CW-1:0] FIRST_SAMPLE = CW'(LAT);

  // Parameter sanity hook; an out-of-range build elaborates this empty block.
  if (N < 2 || W < 2 || LAT < 1 || TIMEOUT < 1) begin : g_param_out_of_range
  end

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [W-1:0]    word;
  logic [CW-1:0]   cyc;
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_next;
  logic [W-1:0]    pick_word;
  logic            sample;

`ifdef SEQ_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT-1);
  logic [TW-1:0] wait_cnt;
`endif

  // First requesting index at or after the pointer, wrapping modulo N.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int o = 0; o < N; o++) begin
      cand = PW'((int'(ptr) + o) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    ptr_next  = PW'((int'(pick) + 1) % N);
    pick_word = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == PW'(i)) pick_word = req_data[i*W +: W];
    end
  end

  always_comb begin
    gnt = '0;
    if (rst && state == IDLE && found) gnt[pick] = 1'b1;
  end

  assign det_rst = !rst || (state == CLR);
  assign sample  = (state == SHIFT || state == DRAIN) && (cyc >= FIRST_SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      word        <= '0;
      cyc         <= '0;
      busy        <= 1'b0;
      det_x       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_count  <= '0;
      resp_last_y <= 2'b00;
`ifdef SEQ_SCHED_TIMEOUT_EN
      resp_drop   <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
`ifdef SEQ_SCHED_TIMEOUT_EN
      resp_drop <= 1'b0;
`endif
      if (sample && det_y != 2'b00) begin
        resp_count  <= resp_count + CNTW'(1);
        resp_last_y <= det_y;
      end
      case (state)
        IDLE: begin
          if (found) begin
            word    <= pick_word;
            resp_id <= pick;
            ptr     <= ptr_next;
            busy    <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          resp_count  <= '0;
          resp_last_y <= 2'b00;
          cyc         <= '0;
          det_x       <= word[W-1];
          word        <= word << 1;
          state       <= SHIFT;
        end
        SHIFT: begin
          cyc <= cyc + CW'(1);
          if (cyc == SHIFT_LAST) begin
            det_x <= 1'b0;
            state <= DRAIN;
          end else begin
            det_x <= word[W-1];
            word  <= word << 1;
          end
        end
        DRAIN: begin
          cyc <= cyc + CW'(1);
          if (cyc == DRAIN_LAST) begin
            resp_valid <= 1'b1;
            state      <= DONE;
`ifdef SEQ_SCHED_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef SEQ_SCHED_TIMEOUT_EN
          end else if (wait_cnt == WAIT_LAST) begin
            resp_valid <= 1'b0;
            resp_drop  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler with a LAT=1 "101" Moore detector model.
// Build with SEQ_SCHED_TIMEOUT_EN defined to exercise the resp_drop timeout path.
`timescale 1ns/1ps
module tb_seq_det_scheduler;
  localparam int N       = 2;
  localparam int W       = 8;
  localparam int LAT     = 1;
  localparam int TIMEOUT = 64;
  localparam int RESP_T  = W + 2 + LAT;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           det_rst;
  logic           det_x;
  logic [1:0]     det_y;
  logic           resp_valid;
  logic           resp_ready;
  logic [$clog2(N)-1:0]   resp_id;
  logic [$clog2(W+1)-1:0] resp_count;
  logic [1:0]     resp_last_y;
`ifdef SEQ_SCHED_TIMEOUT_EN
  logic           resp_drop;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_det_scheduler #(.N(N), .W(W), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .det_rst(det_rst), .det_x(det_x), .det_y(det_y), .resp_valid(resp_valid),
`ifdef SEQ_SCHED_TIMEOUT_EN
    .resp_drop(resp_drop),
`endif
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_count(resp_count),
    .resp_last_y(resp_last_y)
  );

  // Detector: Moore output, one cycle after the bit is shifted in.
  logic [2:0] hist;
  always @(posedge clk) begin
    if (det_rst) hist <= 3'b000;
    else         hist <= {hist[1:0], det_x};
  end
  assign det_y = (hist == 3'b101) ? 2'b10 : 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] q, input logic [W-1:0] w0,
                               input logic [W-1:0] w1, input logic rr);
    @(posedge clk);
    #1;
    rst        = r;
    req        = q;
    req_data   = {w1, w0};
    resp_ready = rr;
  endtask

  function automatic int rrPick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++) begin
      if (r[(p + o) % N]) return (p + o) % N;
    end
    return -1;
  endfunction

  function automatic void scanWord(input logic [W-1:0] wd, output int cnt, output logic [1:0] last);
    logic [2:0] three;
    three = 3'b000;
    cnt   = 0;
    last  = 2'b00;
    for (int j = 0; j < W; j++) begin
      three = {three[1:0], wd[W-1-j]};
      if (three == 3'b101) begin
        cnt++;
        last = 2'b10;
      end
    end
  endfunction

  // Transaction-level reference: time since grant drives every expected output.
  bit         m_known = 0;
  bit         m_active = 0;
  bit         m_drop = 0;
  int         m_t, m_ptr, m_id, m_cnt;
  logic [W-1:0] m_word;
  logic [1:0] m_last;

  always @(negedge clk) begin
    int pk;
    logic [N-1:0] eg;
    logic exp_valid;
    logic exp_x;
    pk = -1;
    exp_valid = m_active && (m_t >= RESP_T);
    if (m_known) begin
      pk = rrPick(req, m_ptr);
      eg = '0;
      if (rst && !m_active && pk >= 0) eg[pk] = 1'b1;
      checkOutput("mon_gnt", gnt, eg);
      checkOutput("mon_busy", busy, m_active);
      checkOutput("mon_det_rst", det_rst, !rst || (m_active && m_t == 1));
      exp_x = (m_active && m_t >= 2 && m_t <= W + 1) ? m_word[W-1-(m_t-2)] : 1'b0;
      checkOutput("mon_det_x", det_x, exp_x);
      checkOutput("mon_resp_valid", resp_valid, exp_valid);
      if (exp_valid) begin
        checkOutput("mon_resp_id", resp_id, m_id);
        checkOutput("mon_resp_count", resp_count, m_cnt);
        checkOutput("mon_resp_last_y", resp_last_y, m_last);
      end
`ifdef SEQ_SCHED_TIMEOUT_EN
      checkOutput("mon_resp_drop", resp_drop, m_drop);
`endif
    end
    m_drop = 1'b0;
    if (!rst) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (m_known) begin
      if (!m_active) begin
        if (pk >= 0) begin
          m_active = 1'b1;
          m_t      = 1;
          m_id     = pk;
          m_word   = req_data[pk*W +: W];
          scanWord(m_word, m_cnt, m_last);
          m_ptr    = (pk + 1) % N;
        end
      end else if (exp_valid && resp_ready) begin
        m_active = 1'b0;
`ifdef SEQ_SCHED_TIMEOUT_EN
      end else if (exp_valid && (m_t - RESP_T + 1) == TIMEOUT) begin
        m_active = 1'b0;
        m_drop   = 1'b1;
`endif
      end else begin
        m_t++;
      end
    end
  end

  task automatic waitGrant(output int who, input int limit);
    who = -1;
    for (int c = 0; c < limit && who < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) who = i;
    end
    if (who < 0) checkOutput("wait_grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitValid(input int limit);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) checkOutput("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int who;
    int nvalid;
    logic [W-1:0] exp_bits;
    rst = 1'b0; req = 2'b11; req_data = '0; resp_ready = 1'b1;

    // Reset with both requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t1_gnt", gnt, 2'b00);
      checkOutput("t1_busy", busy, 1'b0);
      checkOutput("t1_resp_valid", resp_valid, 1'b0);
      checkOutput("t1_det_rst", det_rst, 1'b1);
      checkOutput("t1_resp_count", resp_count, 0);
      checkOutput("t1_resp_last_y", resp_last_y, 2'b00);
    end
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t1_first_gnt", gnt, 2'b01);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    waitIdle(40);

    // Single request with two overlapping "101" hits.
    exp_bits = 8'b10101000;
    applyStimulus(1'b1, 2'b01, exp_bits, 8'h00, 1'b1);
    waitGrant(who, 4);
    checkOutput("t2_gnt_id", who, 0);
    applyStimulus(1'b1, 2'b00, exp_bits, 8'h00, 1'b1);
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      checkOutput("t2_det_x", det_x, exp_bits[W-1-k]);
    end
    @(negedge clk);
    checkOutput("t2_valid_early", resp_valid, 1'b0);
    @(negedge clk);
    checkOutput("t2_valid", resp_valid, 1'b1);
    checkOutput("t2_count", resp_count, 2);
    checkOutput("t2_last_y", resp_last_y, 2'b10);
    checkOutput("t2_id", resp_id, 0);
    @(negedge clk);
    checkOutput("t2_idle", busy, 1'b0);

    // Arbitration from a fresh pointer with both requests held.
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 2'b11, 8'hFF, 8'b01010000, 1'b1);
    for (int g = 0; g < 4; g++) begin
      waitGrant(who, 40);
      checkOutput("t3_order", who, g % 2);
      if (g == 3) applyStimulus(1'b1, 2'b00, 8'hFF, 8'b01010000, 1'b1);
      waitValid(40);
      checkOutput("t3_id", resp_id, g % 2);
      checkOutput("t3_count", resp_count, (g % 2 == 1) ? 1 : 0);
      checkOutput("t3_last_y", resp_last_y, (g % 2 == 1) ? 2'b10 : 2'b00);
    end
    waitIdle(40);

    // Backpressure while another request waits.
    applyStimulus(1'b1, 2'b10, 8'h00, 8'b01010000, 1'b0);
    waitGrant(who, 4);
    checkOutput("t4_gnt_id", who, 1);
    applyStimulus(1'b1, 2'b01, 8'h00, 8'b01010000, 1'b0);
    waitValid(20);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t4_valid_hold", resp_valid, 1'b1);
      checkOutput("t4_busy_hold", busy, 1'b1);
      checkOutput("t4_no_gnt", gnt, 2'b00);
      checkOutput("t4_id_hold", resp_id, 1);
      checkOutput("t4_count_hold", resp_count, 1);
      checkOutput("t4_last_hold", resp_last_y, 2'b10);
    end
    applyStimulus(1'b1, 2'b01, 8'h00, 8'b01010000, 1'b1);
    @(negedge clk);
    checkOutput("t4_valid_at_ready", resp_valid, 1'b1);
    @(negedge clk);
    checkOutput("t4_idle_after", busy, 1'b0);
    checkOutput("t4_next_gnt", gnt, 2'b01);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    waitIdle(40);

    // Reset in the middle of SHIFT (k=4).
    applyStimulus(1'b1, 2'b01, 8'b10110101, 8'h00, 1'b1);
    waitGrant(who, 4);
    checkOutput("t5_gnt_id", who, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 8'b10110101, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_det_rst", det_rst, 1'b1);
    checkOutput("t5_valid", resp_valid, 1'b0);
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t5_ptr_zero", gnt, 2'b01);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    waitIdle(40);

`ifdef SEQ_SCHED_TIMEOUT_EN
    // Consumer never ready: response is dropped after TIMEOUT valid cycles.
    applyStimulus(1'b1, 2'b01, 8'b10100000, 8'h00, 1'b0);
    waitGrant(who, 4);
    applyStimulus(1'b1, 2'b00, 8'b10100000, 8'h00, 1'b0);
    waitValid(30);
    nvalid = 1;
    for (int c = 0; c < 200 && resp_valid; c++) begin
      @(negedge clk);
      if (resp_valid) nvalid++;
    end
    checkOutput("t6_valid_cycles", nvalid, TIMEOUT);
    checkOutput("t6_drop", resp_drop, 1'b1);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_count_kept", resp_count, 1);
    checkOutput("t6_last_kept", resp_last_y, 2'b10);
    checkOutput("t6_id_kept", resp_id, 0);
    @(negedge clk);
    checkOutput("t6_drop_pulse", resp_drop, 1'b0);
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
    waitGrant(who, 4);
    checkOutput("t6_regrant", who, 1);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    waitIdle(40);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Round-robin scheduler that shares one serial sequence-detector instance between N requesters. Each requester presents a W-bit word. The scheduler grants one requester, clears the detector, shifts the word into the detector MSB-first on det_x, and collects the detector's 2-bit output codes. It then returns a match count and the last code through a valid/ready response port. It sits between the requester blocks and the single detector instance.

Parameters:
N, 2, number of requesters (2..8)
W, 8, bits per word shifted into the detector (2..32)
LAT, 1, detector output latency in cycles from det_x edge to det_y (1..3)
TIMEOUT, 64, resp_ready wait limit in cycles (used only with SEQ_SCHED_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
req  input  N  per-requester request; held high until granted
req_data  input  N*W  word of requester i at bits [i*W +: W]
gnt  output  N  one-hot, one-cycle pulse; word of the granted requester captured that cycle
busy  output  1  high in every state except IDLE
det_rst  output  1  active-high reset to the detector
det_x  output  1  serial bit to the detector
det_y  input  2  detector output code
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_id  output  $clog2(N)  index of the served requester
resp_count  output  $clog2(W+1)  number of samples with det_y != 2'b00
resp_last_y  output  2  last nonzero det_y sampled; 2'b00 if none

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; round-robin pointer=0.
  - gnt=0, busy=0, det_x=0, resp_valid=0, resp_id=0, resp_count=0, resp_last_y=0.
  - det_rst=1 while rst is low.
  - Reset mid-transaction aborts it with no response.
- States: IDLE -> CLR -> SHIFT -> DRAIN -> DONE -> IDLE.
- IDLE:
  - det_rst=0, det_x=0.
  - If any req bit is high, grant the first requester at or after the pointer (wrapping modulo N).
  - In the grant cycle: gnt[i]=1, capture req_data[i], resp_id<=i, pointer<=(i+1) mod N, go to CLR.
  - No request: stay in IDLE. req bits that are not granted are ignored and must stay held.
- CLR: one cycle; det_rst=1, det_x=0. Clear the count and last_y.
- SHIFT: W cycles, index k=0..W-1.
  - det_x = word bit [W-1-k], registered.
  - det_y is sampled in cycles with k>=LAT.
- DRAIN: LAT cycles; det_x=0; det_y is sampled every cycle.
- Sample count: exactly W samples in total; the sample for bit j falls in cycle j+LAT after SHIFT starts.
- Per sample: if det_y!=0, count+1 and last_y<=det_y.
- Count width: $clog2(W+1); it cannot overflow.
- DONE:
  - resp_valid=1; resp_id, resp_count and resp_last_y stable until handshake.
  - resp_valid&&resp_ready: resp_valid drops next cycle, go to IDLE.
  - Earliest next grant is the cycle after DONE exits, so there is no grant while busy.
- Timing: gnt pulse in cycle T; CLR in T+1; SHIFT in T+2..T+1+W; DRAIN in T+2+W..T+1+W+LAT; resp_valid first high in T+2+W+LAT.
- Simultaneous requests: round-robin order. A requester that is granted twice in a row only does so when no other req is high.
- resp_ready is ignored outside DONE.

Optional Feature:
SEQ_SCHED_TIMEOUT_EN:
- Defined:
  - Adds output resp_drop (1 bit, reset 0).
  - If resp_valid stays high for TIMEOUT cycles without resp_ready, resp_valid drops, resp_drop pulses high for 1 cycle, and state returns to IDLE.
  - resp_id, resp_count and resp_last_y keep their values.
- Undefined: no resp_drop port; DONE waits indefinitely.

Test Plan:
Bench detector model: Moore, LAT=1, y=2'b10 when the last three bits are 101 (overlapping matches allowed); det_rst clears its history. Parameters N=2, W=8.
1. Reset: rst=0 for 3 cycles with req=2'b11 -> gnt=0, busy=0, resp_valid=0, det_rst=1; first grant after release is gnt=2'b01.
2. Single request: req=2'b01, word0=8'b10101000 -> det_x shows 1,0,1,0,1,0,0,0 in cycles T+2..T+9; resp_valid at T+11; resp_count=2, resp_last_y=2'b10, resp_id=0.
3. Arbitration: req=2'b11 held, word0=8'hFF, word1=8'b01010000 -> grant order 0,1,0,1. Requester 0: count=0, last_y=0. Requester 1: count=1, last_y=2'b10.
4. Backpressure: resp_ready=0 for 20 cycles in DONE -> resp_valid and all resp fields stable, busy=1, no gnt; resp_ready=1 -> IDLE next cycle.
5. Mid-operation reset: rst=0 during SHIFT k=4 -> next cycle state IDLE, det_rst=1, no resp_valid; after release the pointer is 0.
6. SEQ_SCHED_TIMEOUT_EN, TIMEOUT=64: resp_ready held 0 -> resp_drop pulses once after 64 resp_valid cycles, then a new grant is possible.
